hpdmc_initseq: RTL and testbench

Hardware initiator for the HPDMC control-interface CSR bank: after `start`, it autonomously performs the DDR SDRAM power-up sequence by issuing CSR reads and writes. The sequence covers PLL-lock polling, the CKE bring-up, PRECHARGE/LOAD MODE/AUTO REFRESH commands and the timing load, then releases bypass so the HPDMC takes over. It sits beside the CPU on the CSR bus and owns the bus only while `busy` is high; the system mux selects its outputs on `busy`.

---
 rtl/hpdmc_initseq.sv | 183 ++++++++++++++++++
 tb/tb_hpdmc_initseq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdmc_initseq.sv
// hpdmc_initseq: DDR SDRAM power-up sequencer that masters the HPDMC CSR bank while busy.
// Define HPDMC_INITSEQ_IDELAY_EN to append an idelay_rst pulse write (reg3 <- 0x1).
module hpdmc_initseq #(
    parameter logic [3:0]  csr_addr    = 4'h0,
    parameter logic [15:0] init_wait   = 16'd20000,
    parameter logic [15:0] dll_wait    = 16'd200,
    parameter logic [3:0]  cmd_gap     = 4'd8,
    parameter logic [15:0] pll_timeout = 16'd50000,
    parameter logic [12:0] mr          = 13'h023,
    parameter logic [12:0] emr         = 13'h000,
    parameter logic [23:0] timing      = 24'h0509B1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    output logic [13:0] csr_a,
    output logic        csr_we,
    output logic [31:0] csr_di,
    input  logic [31:0] csr_do,
    output logic        busy,
    output logic        done,
    output logic        error
);
    // state  | meaning
    // IDLE   | bus released, waiting for start
    // POLL_A | reg3 address presented to the bank
    // POLL_L | bank read latency
    // POLL_S | pll_stat on csr_do[7:6] sampled
    // WAIT   | write issued, counting its post-write gap

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_POLL_A = 3'd1;
    localparam logic [2:0] S_POLL_L = 3'd2;
    localparam logic [2:0] S_POLL_S = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;

`ifdef HPDMC_INITSEQ_IDELAY_EN
    localparam logic [3:0] NUM_STEPS = 4'd12;
`else
    localparam logic [3:0] NUM_STEPS = 4'd11;
`endif

    localparam logic [15:0] POLL_LOAD = (pll_timeout == 16'd0) ? 16'd0 : pll_timeout - 16'd1;

    logic [2:0]  r_state;
    logic [3:0]  r_step;
    logic [15:0] r_wait;
    logic [13:0] r_csr_a;
    logic        r_csr_we;
    logic [31:0] r_csr_di;
    logic        r_busy;
    logic        r_done;
    logic        r_error;

    logic [1:0]  w_step_reg;
    logic [31:0] w_step_data;
    logic [15:0] w_step_wait;
    logic        w_polling;
    logic        w_locked;
    logic        w_gap_done;
    logic        w_issue;
    logic        w_finish;
    logic        w_abort;
    logic        w_unused_do;

    assign w_unused_do = ^{csr_do[31:8], csr_do[5:0]};

    // r_step is both the index of the next write and the count of writes already issued.
    always_comb begin
        w_step_reg  = 2'd1;
        w_step_data = 32'd0;
        w_step_wait = {12'd0, cmd_gap};
        case (r_step)
            4'd0: begin
                w_step_reg  = 2'd0;
                w_step_data = 32'h0000_0003;
                w_step_wait = init_wait;
            end
            4'd1: begin
                w_step_reg  = 2'd0;
                w_step_data = 32'h0000_0007;
            end
            4'd2, 4'd5: w_step_data = 32'h0000_400B;
            4'd3:       w_step_data = {14'd0, 1'b1, emr, 4'hF};
            4'd4:       w_step_data = {15'd0, mr | 13'h100, 4'hF};
            4'd6, 4'd7: w_step_data = 32'h0000_000D;
            4'd8: begin
                w_step_data = {15'd0, mr, 4'hF};
                w_step_wait = dll_wait;
            end
            4'd9: begin
                w_step_reg  = 2'd2;
                w_step_data = {8'd0, timing};
            end
            4'd10: begin
                w_step_reg  = 2'd0;
                w_step_data = 32'h0000_0004;
            end
`ifdef HPDMC_INITSEQ_IDELAY_EN
            4'd11: begin
                w_step_reg  = 2'd3;
                w_step_data = 32'h0000_0001;
            end
`endif
            default: ;
        endcase
    end

    assign w_polling  = (r_state == S_POLL_A) || (r_state == S_POLL_L) || (r_state == S_POLL_S);
    assign w_locked   = (r_state == S_POLL_S) && (csr_do[7:6] == 2'b11);
    assign w_gap_done = (r_state == S_WAIT) && (r_wait == 16'd0);
    assign w_issue    = w_locked || (w_gap_done && (r_step != NUM_STEPS));
    assign w_finish   = w_gap_done && (r_step == NUM_STEPS);
    // A lock seen on the very last allowed poll cycle still counts as locked.
    assign w_abort    = w_polling && !w_locked && (r_wait == 16'd0);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state  <= S_IDLE;
            r_step   <= 4'd0;
            r_wait   <= 16'd0;
            r_csr_a  <= 14'd0;
            r_csr_we <= 1'b0;
            r_csr_di <= 32'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_csr_we <= 1'b0;
            if (w_issue) begin
                r_csr_we <= 1'b1;
                r_csr_a  <= {csr_addr, 8'd0, w_step_reg};
                r_csr_di <= w_step_data;
                r_wait   <= w_step_wait;
                r_step   <= r_step + 4'd1;
                r_state  <= S_WAIT;
            end else if (w_finish || w_abort) begin
                r_state  <= S_IDLE;
                r_busy   <= 1'b0;
                r_done   <= w_finish;
                r_error  <= w_abort;
                r_csr_a  <= 14'd0;
                r_csr_di <= 32'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_error <= 1'b0;
                            r_step  <= 4'd0;
                            r_wait  <= POLL_LOAD;
                            r_csr_a <= {csr_addr, 8'd0, 2'd3};
                            r_state <= S_POLL_A;
                        end
                    end
                    S_POLL_A: begin
                        r_wait  <= r_wait - 16'd1;
                        r_state <= S_POLL_L;
                    end
                    S_POLL_L: begin
                        r_wait  <= r_wait - 16'd1;
                        r_state <= S_POLL_S;
                    end
                    S_POLL_S: begin
                        r_wait  <= r_wait - 16'd1;
                        r_state <= S_POLL_A;
                    end
                    S_WAIT:  r_wait <= r_wait - 16'd1;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign csr_a  = r_csr_a;
    assign csr_we = r_csr_we;
    assign csr_di = r_csr_di;
    assign busy   = r_busy;
    assign done   = r_done;
    assign error  = r_error;

endmodule

// File: tb/tb_hpdmc_initseq.sv
// tb_hpdmc_initseq: randomized self-checking bench for the HPDMC power-up sequencer.
// Expects the extra idelay_rst write when HPDMC_INITSEQ_IDELAY_EN is defined.
`timescale 1ns/1ps
module tb_hpdmc_initseq;
    localparam logic [3:0]  CSR_ADDR    = 4'hA;
    localparam logic [15:0] INIT_WAIT   = 16'd20000;
    localparam logic [15:0] DLL_WAIT    = 16'd200;
    localparam logic [3:0]  CMD_GAP     = 4'd8;
    localparam logic [15:0] PLL_TIMEOUT = 16'd100;
    localparam logic [12:0] MR          = 13'h023;
    localparam logic [12:0] EMR         = 13'h000;
    localparam logic [23:0] TIMING      = 24'h0509B1;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        start;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;
    logic        busy;
    logic        done;
    logic        error;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rel     = 0;
    int pll_mode = 0;
    int lock_at  = 0;
    logic [1:0]  unlock_pat = 2'b01;
    logic [31:0] noise;
    logic [1:0]  stat;

    logic [13:0] wr_a[$];
    logic [31:0] wr_d[$];
    int          wr_t[$];
    int          wr_r[$];
    logic [13:0] exp_a[$];
    logic [31:0] exp_d[$];
    int          exp_gap[$];

    hpdmc_initseq #(
        .csr_addr(CSR_ADDR), .init_wait(INIT_WAIT), .dll_wait(DLL_WAIT), .cmd_gap(CMD_GAP),
        .pll_timeout(PLL_TIMEOUT), .mr(MR), .emr(EMR), .timing(TIMING)
    ) u_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .csr_a(csr_a), .csr_we(csr_we),
        .csr_di(csr_di), .csr_do(csr_do), .busy(busy), .done(done), .error(error)
    );

    always #5 sys_clk = ~sys_clk;

    // rel = 1 in the first cycle after an accepted start
    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (start && !busy && !sys_rst) rel <= 1;
        else rel <= rel + 1;
    end

    // Write logger and PLL-status responder
    always @(negedge sys_clk) begin
        if (csr_we) begin
            wr_a.push_back(csr_a);
            wr_d.push_back(csr_di);
            wr_t.push_back(cyc);
            wr_r.push_back(rel);
        end
        noise = $urandom();
        if (pll_mode == 0) stat = 2'b11;
        else if (pll_mode == 1) stat = (rel >= lock_at) ? 2'b11 : unlock_pat;
        else stat = unlock_pat;
        csr_do = {noise[31:8], stat, noise[5:0]};
    end

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_log();
        wr_a.delete(); wr_d.delete(); wr_t.delete(); wr_r.delete();
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        for (int k = 0; k < budget && busy; k++) tick();
        ok = !busy;
    endtask

    task automatic push_exp(input int r, input int d, input int gap);
        exp_a.push_back(14'(int'(CSR_ADDR) * 1024 + r));
        exp_d.push_back(32'(d));
        exp_gap.push_back(gap);
    endtask

    task automatic build_model();
        int g;
        g = int'(CMD_GAP) + 1;
        exp_a.delete(); exp_d.delete(); exp_gap.delete();
        push_exp(0, 3, int'(INIT_WAIT) + 1);
        push_exp(0, 7, g);
        push_exp(1, (1 << 14) + 11, g);
        push_exp(1, (1 << 17) + int'(EMR) * 16 + 15, g);
        push_exp(1, (int'(MR) | 256) * 16 + 15, g);
        push_exp(1, (1 << 14) + 11, g);
        push_exp(1, 13, g);
        push_exp(1, 13, g);
        push_exp(1, int'(MR) * 16 + 15, int'(DLL_WAIT) + 1);
        push_exp(2, int'(TIMING), g);
        push_exp(0, 4, g);
`ifdef HPDMC_INITSEQ_IDELAY_EN
        push_exp(3, 1, g);
`endif
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        start   = 1'b0;
        tick();
        n_tests++; if (csr_a !== 14'd0) begin n_fail++; $display("FAIL reset_csr_a: got %h, want 0", csr_a); end
        n_tests++; if (csr_we !== 1'b0) begin n_fail++; $display("FAIL reset_csr_we: got %b, want 0", csr_we); end
        n_tests++; if (csr_di !== 32'd0) begin n_fail++; $display("FAIL reset_csr_di: got %h, want 0", csr_di); end
        n_tests++; if ({busy, done, error} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: busy/done/error=%b, want 000", {busy, done, error}); end
        tick();
        sys_rst = 1'b0;
        tick();
    endtask

    task automatic test_locked_defaults();
        bit ok;
        int n;
        pll_mode = 0;
        clear_log();
        pulse_start();
        n_tests++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL start_flags: busy=%b done=%b, want busy=1 done=0", busy, done); end
        wait_idle(30000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL seq_timeout: busy still %b after 30000 cycles, want 0", busy); end
        n_tests++; if (wr_a.size() != exp_a.size()) begin n_fail++; $display("FAIL write_count: got %0d, want %0d", wr_a.size(), exp_a.size()); end
        n = (wr_a.size() < exp_a.size()) ? wr_a.size() : exp_a.size();
        for (int i = 0; i < n; i++) begin
            n_tests++;
            if (wr_a[i] !== exp_a[i] || wr_d[i] !== exp_d[i]) begin
                n_fail++;
                $display("FAIL write_%0d: got a=%h d=%h, want a=%h d=%h", i, wr_a[i], wr_d[i], exp_a[i], exp_d[i]);
            end
            if (i + 1 < n) begin
                n_tests++;
                if (wr_t[i+1] - wr_t[i] != exp_gap[i]) begin
                    n_fail++;
                    $display("FAIL spacing_%0d: got %0d cycles, want %0d", i, wr_t[i+1] - wr_t[i], exp_gap[i]);
                end
            end
        end
        n_tests++; if ({done, busy, error} !== 3'b100) begin n_fail++; $display("FAIL end_flags: done/busy/error=%b, want 100", {done, busy, error}); end
        n_tests++; if (csr_a !== 14'd0 || csr_di !== 32'd0 || csr_we !== 1'b0) begin n_fail++; $display("FAIL end_outputs: a=%h di=%h we=%b, want all 0", csr_a, csr_di, csr_we); end
        repeat (5) tick();
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_sticky: got %b, want 1", done); end
    endtask

    task automatic test_poll_delay();
        for (int it = 0; it < 4; it++) begin
            int n;
            int k;
            n = (it == 0) ? 11 : int'($urandom_range(1, 20));
            unlock_pat = (it == 0) ? 2'b01 : 2'($urandom_range(0, 2));
            pll_mode = 1;
            lock_at  = 3 * n - 2;
            clear_log();
            pulse_start();
            k = 0;
            while (wr_a.size() == 0 && k < 3 * n + 10) begin tick(); k++; end
            n_tests++;
            if (wr_a.size() == 0) begin
                n_fail++;
                $display("FAIL poll_first_write: no write after %0d polls, want write at cycle %0d", n, 3 * n + 1);
            end else begin
                n_tests++;
                if (wr_r[0] != 3 * n + 1 || wr_d[0] !== exp_d[0]) begin
                    n_fail++;
                    $display("FAIL poll_lock_%0d: first write cycle %0d data %h, want cycle %0d data %h", n, wr_r[0], wr_d[0], 3 * n + 1, exp_d[0]);
                end
            end
            sys_rst = 1'b1;
            tick();
            sys_rst = 1'b0;
            tick();
        end
    endtask

    task automatic test_timeout();
        int k;
        pll_mode   = 2;
        unlock_pat = 2'($urandom_range(0, 2));
        clear_log();
        pulse_start();
        k = 1;
        while (!error && k < int'(PLL_TIMEOUT) + 3) begin tick(); k++; end
        n_tests++; if (error !== 1'b1) begin n_fail++; $display("FAIL timeout_error: got %b, want 1 within %0d cycles", error, int'(PLL_TIMEOUT) + 3); end
        n_tests++; if (rel < int'(PLL_TIMEOUT) || rel > int'(PLL_TIMEOUT) + 3) begin n_fail++; $display("FAIL timeout_cycle: error at cycle %0d, want %0d..%0d", rel, int'(PLL_TIMEOUT), int'(PLL_TIMEOUT) + 3); end
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL timeout_flags: busy=%b done=%b, want 0 0", busy, done); end
        n_tests++; if (wr_a.size() != 0) begin n_fail++; $display("FAIL timeout_writes: got %0d writes, want 0", wr_a.size()); end
        repeat (4) tick();
        n_tests++; if (error !== 1'b1) begin n_fail++; $display("FAIL error_sticky: got %b, want 1", error); end
    endtask

    task automatic test_reset_midrun();
        int k;
        pll_mode = 0;
        clear_log();
        pulse_start();
        n_tests++; if (error !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL start_clears_error: error=%b busy=%b, want 0 1", error, busy); end
        k = 0;
        while (wr_a.size() < 5 && k < 25000) begin tick(); k++; end
        n_tests++;
        if (wr_a.size() != 5) begin
            n_fail++;
            $display("FAIL reach_step4: got %0d writes, want 5", wr_a.size());
        end else begin
            n_tests++;
            if (wr_d[4] !== exp_d[4] || csr_we !== 1'b1) begin
                n_fail++;
                $display("FAIL step4_write: d=%h we=%b, want d=%h we=1", wr_d[4], csr_we, exp_d[4]);
            end
        end
        sys_rst = 1'b1;
        #1;
        n_tests++;
        if ({csr_a, csr_we, csr_di, busy, done, error} !== 50'd0) begin
            n_fail++;
            $display("FAIL reset_midrun: a=%h we=%b di=%h busy=%b done=%b error=%b, want all 0", csr_a, csr_we, csr_di, busy, done, error);
        end
        tick();
        sys_rst = 1'b0;
        repeat (3) tick();
        n_tests++; if (busy !== 1'b0 || csr_we !== 1'b0) begin n_fail++; $display("FAIL no_resume: busy=%b we=%b, want 0 0", busy, csr_we); end
    endtask

    task automatic test_restart_start_ignored();
        bit ok;
        int k;
        int n;
        clear_log();
        pulse_start();
        k = 0;
        while (wr_a.size() < 7 && k < 25000) begin tick(); k++; end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(30000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL restart_timeout: busy still %b, want 0", busy); end
        n_tests++; if (wr_a.size() != exp_a.size()) begin n_fail++; $display("FAIL restart_count: got %0d writes, want %0d", wr_a.size(), exp_a.size()); end
        n = (wr_a.size() < exp_a.size()) ? wr_a.size() : exp_a.size();
        for (int i = 0; i < n; i++) begin
            n_tests++;
            if (wr_a[i] !== exp_a[i] || wr_d[i] !== exp_d[i]) begin
                n_fail++;
                $display("FAIL restart_write_%0d: got a=%h d=%h, want a=%h d=%h", i, wr_a[i], wr_d[i], exp_a[i], exp_d[i]);
            end
        end
        n_tests++; if (done !== 1'b1 || error !== 1'b0) begin n_fail++; $display("FAIL restart_done: done=%b error=%b, want 1 0", done, error); end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        csr_do  = 32'd0;
        sys_rst = 1'b1;
        start   = 1'b0;
        build_model();
        test_reset();
        test_locked_defaults();
        test_poll_delay();
        test_timeout();
        test_reset_midrun();
        test_restart_start_ignored();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
